// File: rtl/gpio_controller.sv
// APB slave with a GPIO direction register (CONTROL) and output data register (DATA).
// Zero-wait-state transfers complete in the first access cycle; byte lanes 0/1 map to storage.
module gpio_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GPIO_WIDTH = 9
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  GPIO_PREADY,
  output logic [1:0]            State,
  output logic [GPIO_WIDTH-1:0] GPIO_CONTROL,
  output logic [GPIO_WIDTH-1:0] GPIO_DATA,
  output logic                  PSLVERR
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } apb_state_e;

  apb_state_e            state_q, state_d;
  logic [GPIO_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [GPIO_WIDTH-1:0] data_q, data_d;
  logic [GPIO_WIDTH-1:0] wr_mask;
  logic [GPIO_WIDTH-1:0] rd_reg;
  logic                  addr_valid;
  logic                  sel_ctrl;
  logic                  access;
  logic                  err;
  logic                  wr_en;
  logic                  unused_bits;

  assign unused_bits = ^{PWDATA[DATA_WIDTH-1:GPIO_WIDTH], PSTRB[3:2]};

  always_comb begin
    state_d = StIdle;
    if (PSEL) begin
      state_d = PENABLE ? StAccess : StSetup;
    end
    // The unused 11 encoding falls back to IDLE for one cycle.
    if (!(state_q inside {StIdle, StSetup, StAccess})) begin
      state_d = StIdle;
    end
  end

  assign addr_valid = (PADDR[ADDR_WIDTH-1:2] == '0) && !PADDR[1];
  assign sel_ctrl   = PADDR[0];
  // Only the first access cycle completes; reset suppresses every response.
  assign access     = !PRESETn && PSEL && PENABLE && (state_q == StSetup);
  assign err        = !addr_valid || (PWRITE && (PSTRB[1:0] == 2'b00));
  assign wr_en      = access && PWRITE && !err;

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
      wr_mask[i] = (i < 8) ? PSTRB[0] : PSTRB[1];
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (wr_en) begin
      if (sel_ctrl) begin
        ctrl_d = (ctrl_q & ~wr_mask) | (PWDATA[GPIO_WIDTH-1:0] & wr_mask);
      end else begin
        data_d = (data_q & ~wr_mask) | (PWDATA[GPIO_WIDTH-1:0] & wr_mask);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    rd_reg = '0;
    if (access && !PWRITE && !err) begin
      rd_reg = sel_ctrl ? ctrl_q : data_q;
    end
  end

  assign PRDATA       = {{(DATA_WIDTH - GPIO_WIDTH){1'b0}}, rd_reg};
  assign GPIO_PREADY  = access;
  assign PSLVERR      = access && err;
  assign State        = state_q;
  assign GPIO_CONTROL = ctrl_q;
  assign GPIO_DATA    = data_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller: register writes/reads, byte lanes, errors, phase tracking.
module tb_gpio_controller;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        GPIO_PREADY;
  logic [1:0]  State;
  logic [8:0]  GPIO_CONTROL;
  logic [8:0]  GPIO_DATA;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdata;
  logic        rdy;
  logic        serr;

  gpio_controller #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .GPIO_WIDTH(9)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .GPIO_PREADY (GPIO_PREADY),
    .State       (State),
    .GPIO_CONTROL(GPIO_CONTROL),
    .GPIO_DATA   (GPIO_DATA),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One transfer; leaves PSEL/PENABLE high so a following call is back-to-back.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input bit hold, input bit chk_state,
                     output logic [31:0] rd, output logic ready, output logic slverr);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    if (chk_state) check_eq("state_setup", 32'(State), 32'h1);
    rd = PRDATA; ready = GPIO_PREADY; slverr = PSLVERR;
    @(posedge PCLK);
    #1;
    if (chk_state) check_eq("state_access", 32'(State), 32'h2);
    if (hold) begin
      @(negedge PCLK);
      #1;
      check_eq("hold_pready", 32'(GPIO_PREADY), 32'h0);
      check_eq("hold_prdata", PRDATA, 32'h0);
      @(posedge PCLK);
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
  endtask

  initial begin
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_control", 32'(GPIO_CONTROL), 32'h0);
    check_eq("rst_data", 32'(GPIO_DATA), 32'h0);
    check_eq("rst_state", 32'(State), 32'h0);
    check_eq("rst_pready", 32'(GPIO_PREADY), 32'h0);
    check_eq("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_eq("rst_prdata", PRDATA, 32'h0);
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    check_eq("state_idle", 32'(State), 32'h0);

    // Write CONTROL = 1 with phase tracking, then read it back.
    apb(1'b1, 32'h1, 32'h1, 4'b0001, 1'b0, 1'b1, rdata, rdy, serr);
    check_eq("wr_ctrl_ready", 32'(rdy), 32'h1);
    check_eq("wr_ctrl_err", 32'(serr), 32'h0);
    check_eq("wr_ctrl_val", 32'(GPIO_CONTROL), 32'h001);
    apb(1'b0, 32'h1, 32'h0, 4'b0000, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("rd_ctrl_ready", 32'(rdy), 32'h1);
    check_eq("rd_ctrl_err", 32'(serr), 32'h0);
    check_eq("rd_ctrl_data", rdata, 32'h1);
    idle();

    // Walking-one DATA writes on lane 0; the 256 write leaves bit8 unstrobed.
    for (int i = 0; i < 8; i++) begin
      apb(1'b1, 32'h0, 32'h1 << i, 4'b0001, 1'b0, 1'b0, rdata, rdy, serr);
      check_eq($sformatf("walk_%0d", i), 32'(GPIO_DATA), 32'h1 << i);
    end
    apb(1'b1, 32'h0, 32'd256, 4'b0001, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("walk_256", 32'(GPIO_DATA), 32'h000);
    idle();

    apb(1'b1, 32'h1, 32'd257, 4'b0010, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("lane1_val", 32'(GPIO_CONTROL), 32'h101);
    check_eq("lane1_err", 32'(serr), 32'h0);

    apb(1'b1, 32'h1, 32'h0080_0000, 4'b0100, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("lane2_ready", 32'(rdy), 32'h1);
    check_eq("lane2_err", 32'(serr), 32'h1);
    check_eq("lane2_ctrl", 32'(GPIO_CONTROL), 32'h101);
    apb(1'b1, 32'h1, 32'h0100_0000, 4'b1000, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("lane3_err", 32'(serr), 32'h1);
    check_eq("lane3_ctrl", 32'(GPIO_CONTROL), 32'h101);

    // Invalid-address write must not touch CONTROL or DATA.
    apb(1'b1, 32'h3, 32'h1ff, 4'b0011, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("badwr_err", 32'(serr), 32'h1);
    check_eq("badwr_ctrl", 32'(GPIO_CONTROL), 32'h101);
    check_eq("badwr_data", 32'(GPIO_DATA), 32'h000);

    apb(1'b0, 32'h2, 32'h0, 4'b0000, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("rd_addr2_ready", 32'(rdy), 32'h1);
    check_eq("rd_addr2_err", 32'(serr), 32'h1);
    check_eq("rd_addr2_data", rdata, 32'h0);
    apb(1'b0, 32'h104, 32'h0, 4'b0000, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("rd_high_err", 32'(serr), 32'h1);
    check_eq("rd_high_data", rdata, 32'h0);

    // Both lanes, then a held-PENABLE DATA read with a stray strobe.
    apb(1'b1, 32'h0, 32'hffff_f1a5, 4'b0011, 1'b0, 1'b0, rdata, rdy, serr);
    check_eq("wr_both_data", 32'(GPIO_DATA), 32'h1a5);
    apb(1'b0, 32'h0, 32'h0, 4'b0100, 1'b1, 1'b0, rdata, rdy, serr);
    check_eq("rd_hold_ready", 32'(rdy), 32'h1);
    check_eq("rd_hold_err", 32'(serr), 32'h0);
    check_eq("rd_hold_data", rdata, 32'h1a5);
    idle();

    // Held write: the second access cycle must not write again.
    apb(1'b1, 32'h1, 32'h0aa, 4'b0001, 1'b1, 1'b0, rdata, rdy, serr);
    check_eq("wr_hold_ctrl", 32'(GPIO_CONTROL), 32'h1aa);
    idle();

    // Reset in the access cycle aborts the write.
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h55; PSTRB = 4'b0011;
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1; PRESETn = 1'b1;
    #1;
    check_eq("rst_mid_pready", 32'(GPIO_PREADY), 32'h0);
    @(posedge PCLK);
    #1;
    check_eq("rst_mid_data", 32'(GPIO_DATA), 32'h0);
    check_eq("rst_mid_ctrl", 32'(GPIO_CONTROL), 32'h0);
    check_eq("rst_mid_state", 32'(State), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
